// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Holds the one-hot serializer state encoding, the default clock/baud
// constants and the clocks-per-bit helper.
package uart_tx_buffered_pkg;

  // One-hot serializer states
  typedef enum logic [3:0] {
    UART_IDLE  = 4'b0001,
    UART_START = 4'b0010,
    UART_DATA  = 4'b0100,
    UART_STOP  = 4'b1000
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ = 65_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  // Integer clocks per serial bit (truncating division)
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  localparam int unsigned DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (push), rd_en (pop),
//        rd_data (head byte), empty, full, level (occupancy 0..FIFO_DEPTH).
// A push while full is accepted when a pop happens on the same edge.
module uart_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 4");
  end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_rd;
  logic          w_wr;

  assign empty   = (r_level == '0);
  assign full    = r_level[AW];
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  // Pointers wrap naturally; level tracks net push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: absorbs producer bursts in a FIFO and
// serializes them back-to-back on tx.
// Ports: clk, rst (sync, active-high), sign/tick (byte write strobe),
//        tx (serial line, idle high, registered), busy (combinational:
//        frame in progress or FIFO non-empty), overflow (sticky drop flag),
//        level (FIFO occupancy).
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int unsigned FIFO_DEPTH   = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  sign,
  input  logic                        tick,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  uart_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_overflow;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [7:0]    w_head;
  logic [AW:0]   w_level;
  logic          w_baud_end;

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tick),
    .wr_data (sign),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .level   (w_level)
  );

  assign w_baud_end = (r_baud == CW'(CLKS_PER_BIT - 1));

  // Serializer next-state, pop and next tx value
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      UART_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = UART_START;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      UART_START: begin
        if (w_baud_end) begin
          w_state_nxt = UART_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      UART_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = UART_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[r_bit + 3'd1];
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      UART_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when data is waiting
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = UART_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = UART_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      default: begin
        w_state_nxt = UART_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Serializer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UART_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Sticky drop flag: write while full with no simultaneous pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (tick && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign overflow = r_overflow;
  assign level    = w_level;
  assign busy     = (r_state != UART_IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: three instances (CPB=10 deep
// FIFO, CPB=10 depth-4 FIFO, default parameters) driven by directed and
// random byte streams, with tx decoded back into bytes and compared.
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_d = 1'b1;
  logic [7:0] sign_a = '0, sign_b = '0, sign_d = '0;
  logic       tick_a = 1'b0, tick_b = 1'b0, tick_d = 1'b0;
  logic       tx_a, tx_b, tx_d;
  logic       busy_a, busy_b, busy_d;
  logic       ovf_a, ovf_b, ovf_d;
  logic [8:0] level_a, level_d;
  logic [2:0] level_b;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(256)) dut_a (
    .clk(clk), .rst(rst_a), .sign(sign_a), .tick(tick_a),
    .tx(tx_a), .busy(busy_a), .overflow(ovf_a), .level(level_a));

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .sign(sign_b), .tick(tick_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .level(level_b));

  uart_tx_buffered dut_d (
    .clk(clk), .rst(rst_d), .sign(sign_d), .tick(tick_d),
    .tx(tx_d), .busy(busy_d), .overflow(ovf_d), .level(level_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_d;
    endcase
  endfunction

  // One write strobe on the selected instance; returns #1 after the edge
  task automatic put(input int sel, input logic [7:0] v);
    case (sel)
      0:       begin sign_a = v; tick_a = 1'b1; end
      1:       begin sign_b = v; tick_b = 1'b1; end
      default: begin sign_d = v; tick_d = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    tick_a = 1'b0; tick_b = 1'b0; tick_d = 1'b0;
  endtask

  // Decode one 8N1 frame sampled on falling edges; gap = idle samples
  // before the start bit, shape_ok = every bit held exactly cpb samples
  task automatic rx_frame(input int sel, input int cpb, input int max_wait,
                          output logic [7:0] data, output int gap, output bit shape_ok);
    logic b;
    gap = 0; shape_ok = 1'b1; data = '0;
    @(negedge clk);
    while (get_tx(sel) !== 1'b0 && gap < max_wait) begin
      gap++;
      @(negedge clk);
    end
    if (get_tx(sel) !== 1'b0) begin
      shape_ok = 1'b0;
      return;
    end
    for (int i = 1; i < cpb; i++) begin
      @(negedge clk);
      if (get_tx(sel) !== 1'b0) shape_ok = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b = get_tx(sel);
      data[k] = b;
      for (int i = 1; i < cpb; i++) begin
        @(negedge clk);
        if (get_tx(sel) !== b) shape_ok = 1'b0;
      end
    end
    for (int i = 0; i < cpb; i++) begin
      @(negedge clk);
      if (get_tx(sel) !== 1'b1) shape_ok = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    int          gap;
    bit          ok;
    int          lows;
    string       burst;
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    int          gaps[$];
    bit          oks[$];

    // Reset state of every instance
    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_level_b", 32'(level_b), 32'd0);
    chk("rst_tx_d", 32'(tx_d), 32'd1);
    chk("rst_busy_d", 32'(busy_d), 32'd0);
    @(posedge clk); #1;

    // Single byte 0x56: pop one edge after the write, 100-clock frame
    put(0, 8'h56);
    @(negedge clk);
    chk("single_tx_before_pop", 32'(tx_a), 32'd1);
    chk("single_level", 32'(level_a), 32'd1);
    chk("single_busy", 32'(busy_a), 32'd1);
    rx_frame(0, 10, 0, d, gap, ok);
    chk("single_shape", 32'(ok), 32'd1);
    chk("single_data", 32'(d), 32'h56);
    chk("single_busy_last", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("single_busy_drop", 32'(busy_a), 32'd0);
    chk("single_tx_idle", 32'(tx_a), 32'd1);
    @(posedge clk); #1;

    // Producer burst, one tick every 2 clocks
    burst = "V01 - 1234 V\n\r";
    got.delete(); gaps.delete(); oks.delete();
    fork
      begin
        for (int i = 0; i < burst.len(); i++) begin
          put(0, burst[i]);
          @(posedge clk); #1;
        end
      end
      begin
        for (int f = 0; f < 14; f++) begin
          rx_frame(0, 10, 50, d, gap, ok);
          got.push_back(d); gaps.push_back(gap); oks.push_back(ok);
        end
      end
    join
    for (int f = 0; f < 14; f++) begin
      chk($sformatf("burst_data%0d", f), 32'(got[f]), 32'(burst[f]));
      chk($sformatf("burst_shape%0d", f), 32'(oks[f]), 32'd1);
      if (f > 0) chk($sformatf("burst_gap%0d", f), 32'(gaps[f]), 32'd0);
    end
    chk("burst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    chk("burst_busy_drop", 32'(busy_a), 32'd0);
    @(posedge clk); #1;

    // Random bytes with random spacing, checked against an in-order queue
    exp_q.delete(); got.delete(); gaps.delete(); oks.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] v;
          v = 8'($urandom);
          exp_q.push_back(v);
          put(0, v);
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int f = 0; f < 20; f++) begin
          rx_frame(0, 10, 50, d, gap, ok);
          got.push_back(d); gaps.push_back(gap); oks.push_back(ok);
        end
      end
    join
    for (int f = 0; f < 20; f++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk($sformatf("rand_data%0d", f), 32'(got[f]), 32'(e));
      chk($sformatf("rand_shape%0d", f), 32'(oks[f]), 32'd1);
      if (f > 0) chk($sformatf("rand_gap%0d", f), 32'(gaps[f]), 32'd0);
    end
    chk("rand_ovf", 32'(ovf_a), 32'd0);
    @(posedge clk); #1;

    // Reset during data bit 3 with bytes still queued
    put(0, 8'hA5);
    put(0, 8'h11);
    put(0, 8'h22);
    repeat (42) @(posedge clk);
    #1; rst_a = 1'b1;
    @(posedge clk);
    #1; rst_a = 1'b0;
    @(negedge clk);
    chk("rstmid_tx", 32'(tx_a), 32'd1);
    chk("rstmid_level", 32'(level_a), 32'd0);
    chk("rstmid_busy", 32'(busy_a), 32'd0);
    chk("rstmid_ovf", 32'(ovf_a), 32'd0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    chk("rstmid_no_frames", 32'(lows), 32'd0);
    @(posedge clk); #1;
    put(0, 8'h3C);
    rx_frame(0, 10, 1, d, gap, ok);
    chk("rstmid_new_shape", 32'(ok), 32'd1);
    chk("rstmid_new_data", 32'(d), 32'h3C);
    @(posedge clk); #1;

    // Overflow on depth-4 FIFO: 6 back-to-back writes, last is dropped
    got.delete(); gaps.delete(); oks.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) put(1, 8'(8'h30 + i));
        @(negedge clk);
        chk("ovf_level", 32'(level_b), 32'd4);
        chk("ovf_flag", 32'(ovf_b), 32'd1);
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_frame(1, 10, 20, d, gap, ok);
          got.push_back(d); gaps.push_back(gap); oks.push_back(ok);
        end
      end
    join
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("ovf_data%0d", f), 32'(got[f]), 32'(8'h30 + f));
      chk($sformatf("ovf_shape%0d", f), 32'(oks[f]), 32'd1);
      if (f > 0) chk($sformatf("ovf_gap%0d", f), 32'(gaps[f]), 32'd0);
    end
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_b !== 1'b1) lows++;
    end
    chk("ovf_no_sixth_frame", 32'(lows), 32'd0);
    chk("ovf_busy_idle", 32'(busy_b), 32'd0);
    chk("ovf_sticky", 32'(ovf_b), 32'd1);

    // Write on the STOP->START pop edge while full is accepted
    @(posedge clk); #1; rst_b = 1'b1;
    @(posedge clk); #1; rst_b = 1'b0;
    @(negedge clk);
    chk("fullpop_ovf_cleared", 32'(ovf_b), 32'd0);
    @(posedge clk); #1;
    got.delete(); gaps.delete(); oks.delete();
    fork
      begin
        for (int i = 0; i < 5; i++) put(1, 8'(8'h40 + i));
        @(negedge clk);
        repeat (96) @(posedge clk);
        #1;
        chk("fullpop_level_before", 32'(level_b), 32'd4);
        put(1, 8'h45);
        chk("fullpop_level_after", 32'(level_b), 32'd4);
        chk("fullpop_ovf", 32'(ovf_b), 32'd0);
      end
      begin
        for (int f = 0; f < 6; f++) begin
          rx_frame(1, 10, 20, d, gap, ok);
          got.push_back(d); gaps.push_back(gap); oks.push_back(ok);
        end
      end
    join
    for (int f = 0; f < 6; f++) begin
      chk($sformatf("fullpop_data%0d", f), 32'(got[f]), 32'(8'h40 + f));
      chk($sformatf("fullpop_shape%0d", f), 32'(oks[f]), 32'd1);
      if (f > 0) chk($sformatf("fullpop_gap%0d", f), 32'(gaps[f]), 32'd0);
    end
    chk("fullpop_ovf_end", 32'(ovf_b), 32'd0);
    @(posedge clk); #1;

    // Default parameters: 564 clocks per bit, 5640-clock frame
    put(2, 8'h0A);
    rx_frame(2, 564, 1, d, gap, ok);
    chk("default_shape", 32'(ok), 32'd1);
    chk("default_data", 32'(d), 32'h0A);
    chk("default_busy_last", 32'(busy_d), 32'd1);
    @(negedge clk);
    chk("default_busy_drop", 32'(busy_d), 32'd0);
    chk("default_ovf", 32'(ovf_d), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
